// File: rtl/load_size_unit.sv
// Load path: issues a memory read, waits out MEM_LATENCY, then extracts and extends a word/half/byte.
// Optional macro LOAD_UNSIGNED_EN adds a load_unsigned port that selects zero-extension for LH/LB.
module load_size_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        load_type,
  input  logic [1:0]        addr_low,
`ifdef LOAD_UNSIGNED_EN
  input  logic              load_unsigned,
`endif
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              busy,
  output logic              misaligned
);

  // state   | meaning
  // IDLE    | waiting for start; request legality decided here
  // ISSUE   | mem_rd_en high, wait counter loaded with MEM_LATENCY-1
  // WAIT    | counting down memory latency
  // CAPTURE | extract/extend mem_rdata into load_data
  // DONE    | load_valid high for one cycle
  // ERR     | misaligned high for one cycle, no memory access
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE, S_ERR
  } state_t;

  localparam int CNT_W = 3;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_load_type;
  logic [1:0]        r_addr_low;
  logic              r_mem_rd_en;
  logic              r_load_valid;
  logic              r_busy;
  logic              r_misaligned;
  logic [DATA_W-1:0] r_load_data;

  logic              w_legal;
  logic              w_uns;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic [DATA_W-1:0] w_ext;

`ifdef LOAD_UNSIGNED_EN
  logic r_unsigned;
  assign w_uns = r_unsigned;
`else
  assign w_uns = 1'b0;
`endif

  always_comb begin
    w_legal = 1'b0;
    case (load_type)
      2'b00:   w_legal = (addr_low == 2'b00);
      2'b01:   w_legal = ~addr_low[0];
      2'b10:   w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Little-endian lane select from the latched offset.
  always_comb begin
    w_half = r_addr_low[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_byte = mem_rdata[7:0];
    case (r_addr_low)
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_ext = mem_rdata;
    case (r_load_type)
      2'b01:   w_ext = {{16{w_half[15] & ~w_uns}}, w_half};
      2'b10:   w_ext = {{24{w_byte[7] & ~w_uns}}, w_byte};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_load_type  <= 2'b00;
      r_addr_low   <= 2'b00;
`ifdef LOAD_UNSIGNED_EN
      r_unsigned   <= 1'b0;
`endif
      r_mem_rd_en  <= 1'b0;
      r_load_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_misaligned <= 1'b0;
      r_load_data  <= '0;
    end else begin
      r_mem_rd_en  <= 1'b0;
      r_load_valid <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_load_type <= load_type;
            r_addr_low  <= addr_low;
`ifdef LOAD_UNSIGNED_EN
            r_unsigned  <= load_unsigned;
`endif
            r_busy      <= 1'b1;
            if (w_legal) begin
              r_state     <= S_ISSUE;
              r_mem_rd_en <= 1'b1;
            end else begin
              r_state      <= S_ERR;
              r_misaligned <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= CNT_W'(MEM_LATENCY - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_CAPTURE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_CAPTURE: begin
          r_load_data  <= w_ext;
          r_load_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE, S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en  = r_mem_rd_en;
  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;
  assign busy       = r_busy;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_load_size_unit.sv
// Bench for load_size_unit: two instances (MEM_LATENCY 1 and 3) checked every cycle
// against a timing/extraction model, plus hand-computed literal checks.
module tb_load_size_unit;

  localparam int ML0 = 1;
  localparam int ML1 = 3;
  int ml [2];

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        start_s [2];
  logic [1:0]  ltype   [2];
  logic [1:0]  laddr   [2];
  logic        lu      [2];
  logic        rd_en   [2];
  logic [31:0] rdata   [2];
  logic [31:0] ldata   [2];
  logic        valid   [2];
  logic        busy    [2];
  logic        mis     [2];

  load_size_unit #(.MEM_LATENCY(ML0), .DATA_W(32)) u0 (
    .clk(clk), .reset(rst[0]), .start(start_s[0]), .load_type(ltype[0]), .addr_low(laddr[0]),
`ifdef LOAD_UNSIGNED_EN
    .load_unsigned(lu[0]),
`endif
    .mem_rd_en(rd_en[0]), .mem_rdata(rdata[0]), .load_data(ldata[0]),
    .load_valid(valid[0]), .busy(busy[0]), .misaligned(mis[0]));

  load_size_unit #(.MEM_LATENCY(ML1), .DATA_W(32)) u1 (
    .clk(clk), .reset(rst[1]), .start(start_s[1]), .load_type(ltype[1]), .addr_low(laddr[1]),
`ifdef LOAD_UNSIGNED_EN
    .load_unsigned(lu[1]),
`endif
    .mem_rd_en(rd_en[1]), .mem_rdata(rdata[1]), .load_data(ldata[1]),
    .load_valid(valid[1]), .busy(busy[1]), .misaligned(mis[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, inst, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [1:0] t, input logic [1:0] a,
                                          input logic u, input logic [31:0] w);
    longint v;
    case (t)
      2'd0: return w;
      2'd1: begin
        v = (longint'(w) >> (16 * int'(a[1]))) % 65536;
        if (!u && v >= 32768) v = v - 65536;
        return v[31:0];
      end
      2'd2: begin
        v = (longint'(w) >> (8 * int'(a))) % 256;
        if (!u && v >= 128) v = v - 256;
        return v[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [1:0] t, input logic [1:0] a);
    if (t == 2'd0) return a == 2'd0;
    if (t == 2'd1) return (int'(a) % 2) == 0;
    return t == 2'd2;
  endfunction

  // Model: an accepted request at cycle c occupies cycles c+1..end, where end is
  // c+MEM_LATENCY+3 for a legal load and c+1 for an illegal one.
  bit          m_act [2];
  bit          m_leg [2];
  int          m_c0  [2];
  logic [1:0]  m_t   [2];
  logic [1:0]  m_a   [2];
  logic        m_u   [2];
  logic [31:0] m_d   [2];
  logic [31:0] m_pend[2];

  always @(negedge clk) begin : cmp
    int n, e_end;
    bit e_rd, e_busy, e_val, e_mis;
    n = cyc;
    for (int i = 0; i < 2; i++) begin
      e_rd = 0; e_busy = 0; e_val = 0; e_mis = 0;
      if (!rst[i]) begin
        m_act[i] = 0;
        m_d[i]   = 32'h0;
      end
      if (m_act[i]) begin
        e_end = m_leg[i] ? m_c0[i] + ml[i] + 3 : m_c0[i] + 1;
        if (n > e_end) m_act[i] = 0;
        else begin
          e_busy = (n >= m_c0[i] + 1);
          e_rd   = m_leg[i] && (n == m_c0[i] + 1);
          e_mis  = !m_leg[i] && (n == m_c0[i] + 1);
          e_val  = m_leg[i] && (n == e_end);
          if (m_leg[i] && n == e_end - 1) m_pend[i] = ref_ext(m_t[i], m_a[i], m_u[i], rdata[i]);
          if (e_val) m_d[i] = m_pend[i];
        end
      end
      chk("mem_rd_en",  i, rd_en[i], e_rd);
      chk("busy",       i, busy[i],  e_busy);
      chk("load_valid", i, valid[i], e_val);
      chk("misaligned", i, mis[i],   e_mis);
      chk("load_data",  i, ldata[i], m_d[i]);
      if (rst[i] && start_s[i] && !m_act[i]) begin
        m_act[i] = 1;
        m_c0[i]  = n;
        m_leg[i] = ref_legal(ltype[i], laddr[i]);
        m_t[i]   = ltype[i];
        m_a[i]   = laddr[i];
`ifdef LOAD_UNSIGNED_EN
        m_u[i]   = lu[i];
`else
        m_u[i]   = 1'b0;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, scrambles the request inputs, runs to DONE and checks the literal result.
  task automatic do_load(input int i, input logic [1:0] t, input logic [1:0] a,
                         input logic u, input logic [31:0] w, input logic [31:0] exp);
    ltype[i] = t; laddr[i] = a; lu[i] = u; rdata[i] = w;
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    ltype[i] = 2'b11; laddr[i] = 2'b01; lu[i] = ~u;
    repeat (ml[i] + 2) tick();
    chk("lit_valid", i, valid[i], 1'b1);
    chk("lit_data",  i, ldata[i], exp);
    tick();
  endtask

  task automatic do_bad(input int i, input logic [1:0] t, input logic [1:0] a, input logic [31:0] prev);
    ltype[i] = t; laddr[i] = a;
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    chk("lit_mis",   i, mis[i],   1'b1);
    chk("lit_rd_en", i, rd_en[i], 1'b0);
    tick();
    chk("lit_mis_end", i, mis[i],   1'b0);
    chk("lit_keep",    i, ldata[i], prev);
    chk("lit_idle",    i, busy[i],  1'b0);
  endtask

  initial begin
    ml[0] = ML0; ml[1] = ML1;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; start_s[i] = 1'b0; ltype[i] = 2'b00; laddr[i] = 2'b00;
      lu[i] = 1'b0; rdata[i] = 32'h0; m_act[i] = 0; m_d[i] = 32'h0; m_pend[i] = 32'h0;
      m_leg[i] = 0; m_c0[i] = 0; m_t[i] = 2'b00; m_a[i] = 2'b00; m_u[i] = 1'b0;
    end
    repeat (2) tick();
    chk("rst_data", 0, ldata[0], 32'h0);
    chk("rst_busy", 0, busy[0],  1'b0);
    rst[0] = 1'b1; rst[1] = 1'b1;
    tick();

    // LW with explicit cycle-by-cycle timing on the MEM_LATENCY=1 instance
    ltype[0] = 2'b00; laddr[0] = 2'b00; rdata[0] = 32'hDEADBEEF;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0; ltype[0] = 2'b11; laddr[0] = 2'b01;
    chk("lw_c1_rd",   0, rd_en[0], 1'b1);
    chk("lw_c1_busy", 0, busy[0],  1'b1);
    tick();
    chk("lw_c2_rd", 0, rd_en[0], 1'b0);
    tick();
    tick();
    chk("lw_c4_valid", 0, valid[0], 1'b1);
    chk("lw_c4_data",  0, ldata[0], 32'hDEADBEEF);
    chk("lw_c4_busy",  0, busy[0],  1'b1);
    tick();
    chk("lw_c5_valid", 0, valid[0], 1'b0);
    chk("lw_c5_busy",  0, busy[0],  1'b0);

    do_load(0, 2'b10, 2'b11, 1'b0, 32'h80123456, 32'hFFFFFF80);
`ifdef LOAD_UNSIGNED_EN
    do_load(0, 2'b10, 2'b11, 1'b1, 32'h80123456, 32'h00000080);
    do_load(0, 2'b01, 2'b00, 1'b1, 32'h7FFF8000, 32'h00008000);
    do_load(0, 2'b00, 2'b00, 1'b1, 32'h8000ABCD, 32'h8000ABCD);
`endif
    do_load(0, 2'b10, 2'b01, 1'b0, 32'h80123456, 32'h00000034);
    do_load(0, 2'b01, 2'b10, 1'b0, 32'h7FFF8000, 32'h00007FFF);
    do_load(0, 2'b01, 2'b00, 1'b0, 32'h7FFF8000, 32'hFFFF8000);
    do_bad(0, 2'b00, 2'b01, 32'hFFFF8000);
    do_bad(0, 2'b11, 2'b00, 32'hFFFF8000);
    do_bad(0, 2'b01, 2'b11, 32'hFFFF8000);
    do_load(0, 2'b10, 2'b10, 1'b0, 32'h00A50000, 32'hFFFFFFA5);

    // MEM_LATENCY=3: start while busy is ignored, start right after DONE is accepted
    ltype[1] = 2'b00; laddr[1] = 2'b00; rdata[1] = 32'h12345678;
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    chk("ml3_c1_rd", 1, rd_en[1], 1'b1);
    tick();
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    chk("ml3_c3_rd", 1, rd_en[1], 1'b0);
    repeat (3) tick();
    chk("ml3_c6_valid", 1, valid[1], 1'b1);
    chk("ml3_c6_data",  1, ldata[1], 32'h12345678);
    tick();
    do_load(1, 2'b00, 2'b00, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5);

    // Asynchronous reset in WAIT discards the load
    ltype[1] = 2'b00; laddr[1] = 2'b00; rdata[1] = 32'h11111111;
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    tick();
    #2 rst[1] = 1'b0;
    #1;
    chk("arst_busy",  1, busy[1],  1'b0);
    chk("arst_data",  1, ldata[1], 32'h0);
    chk("arst_valid", 1, valid[1], 1'b0);
    chk("arst_rd",    1, rd_en[1], 1'b0);
    tick();
    rst[1] = 1'b1;
    repeat (6) tick();
    chk("arst_after_data", 1, ldata[1], 32'h0);
    do_load(1, 2'b00, 2'b00, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
    do_load(1, 2'b01, 2'b10, 1'b0, 32'h9ABC0000, 32'hFFFF9ABC);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_size_unit.md
Name: load_size_unit

Overview:
Load-side counterpart of the store write-data path. It issues a memory read, waits out the fixed memory read latency, then extracts a word, halfword or byte from the returned word. It sign-extends the result and presents it to the MDR/register-file write path with a one-cycle valid pulse. It sits between the control unit and memory on the load path of the multicycle datapath.

Parameters:
MEM_LATENCY, 1, number of clock cycles between the mem_rd_en pulse and valid mem_rdata (legal range 1-7).
DATA_W, 32, data width. Only 32 is supported.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  one-cycle load request from the control unit. Sampled only in IDLE.
load_type  input  2  00 LW, 01 LH, 10 LB, 11 reserved.
addr_low  input  2  byte offset of the effective address (ALUOut[1:0]).
mem_rd_en  output  1  one-cycle memory read strobe.
mem_rdata  input  32  word returned by memory.
load_data  output  32  extended load result. Held stable until the next load completes.
load_valid  output  1  one-cycle pulse when load_data is updated.
busy  output  1  high in every state except IDLE.
misaligned  output  1  one-cycle pulse in place of load_valid for an illegal request.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, mem_rd_en=0, load_data=0, load_valid=0, busy=0, misaligned=0, wait counter=0.
- Request capture: on start in IDLE, load_type and addr_low are latched. Later changes to either input have no effect until the next request.
- Alignment check, in IDLE on start:
  - LW requires addr_low=00.
  - LH requires addr_low[0]=0.
  - LB accepts any offset.
  - load_type=11 counts as illegal.
  - Illegal request: go to ERR. No memory access is made.
- FSM states:
  - IDLE: busy=0. On a legal start, go to ISSUE. On an illegal start, go to ERR.
  - ISSUE: mem_rd_en=1 for exactly this one cycle. Counter is loaded with MEM_LATENCY-1. Next state is WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to CAPTURE. With MEM_LATENCY=1, WAIT lasts one cycle.
  - CAPTURE: sample mem_rdata, extract and extend, register load_data. Next state is DONE.
  - DONE: load_valid=1 for this single cycle. Next state is IDLE.
  - ERR: misaligned=1 for one cycle. load_data is unchanged. Next state is IDLE.
- Latency: start at cycle 0 gives mem_rd_en at cycle 1 and load_valid at cycle MEM_LATENCY+3. For MEM_LATENCY=1, load_valid is at cycle 4.
- Extraction (little-endian):
  - LW: load_data = mem_rdata.
  - LH: halfword = mem_rdata[16*addr_low[1] +: 16], sign-extended to 32 bits.
  - LB: byte = mem_rdata[8*addr_low +: 8], sign-extended to 32 bits.
- Back-to-back requests: start is ignored while busy=1. There is no queueing. A start in the same cycle as DONE is ignored. The earliest accepted start is the cycle after DONE, when the FSM is back in IDLE.
- Reset mid-operation: return to IDLE immediately. Any in-flight load is discarded and load_valid is not asserted. load_data returns to 0.
- load_valid and misaligned are never high in the same cycle.

Optional Feature:
Macro LOAD_UNSIGNED_EN.
- Defined:
  - An extra input port load_unsigned (1 bit) is added and latched with load_type on start.
  - When it is 1, LH and LB zero-extend instead of sign-extending (LHU/LBU).
  - LW ignores load_unsigned.
- Not defined:
  - The port is absent.
  - All sub-word loads sign-extend.

Test Plan:
- LW, addr_low=00, mem_rdata=0xDEADBEEF, MEM_LATENCY=1: mem_rd_en pulses at cycle 1. load_valid pulses at cycle 4 with load_data=0xDEADBEEF. busy is high in cycles 1-4.
- LB, addr_low=11, mem_rdata=0x80123456: load_data=0xFFFFFF80. With LOAD_UNSIGNED_EN and load_unsigned=1: load_data=0x00000080.
- LH, addr_low=10, mem_rdata=0x7FFF8000: load_data=0x00007FFF. Repeat with addr_low=00: load_data=0xFFFF8000.
- LW with addr_low=01, and separately load_type=11: misaligned pulses at cycle 1. mem_rd_en never asserts, load_valid stays 0, and load_data keeps its previous value.
- MEM_LATENCY=3: a LW issued at cycle 0 gives load_valid at cycle 6. A second start at cycle 2, while busy, is ignored (only one mem_rd_en is seen). A start at cycle 7 is accepted.
- reset driven low in WAIT, asynchronously between clock edges: outputs go to 0 and busy=0 immediately. After reset is released, no load_valid occurs and a fresh LW completes normally.
